// File: rtl/addsub_pkg.sv
// ----------------------------------------------------------------------------
// addsub_pkg
//   Shared types and constants for the time-shared add/subtract controller.
//
//   addsub_op_e   : operation encoding carried on req_op (ADD=0, SUB=1)
//   addsub_rsp_t  : response record (id, result, flags) for the default
//                   NUM_REQ/WIDTH configuration
//   rr_wrap()     : modular index helper used by the round-robin scan
// ----------------------------------------------------------------------------
package addsub_pkg;

  localparam int ADDSUB_NUM_REQ = 4;
  localparam int ADDSUB_WIDTH   = 64;
  localparam int ADDSUB_ID_W    = $clog2(ADDSUB_NUM_REQ);

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  typedef struct packed {
    logic [ADDSUB_ID_W-1:0]  id;
    logic [ADDSUB_WIDTH-1:0] result;
    logic                    overflow;
    logic                    carry;
    logic                    zero;
  } addsub_rsp_t;

  // (base + offset) mod n, used for wrapping requester indices.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned offset,
                                          input int unsigned n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// ----------------------------------------------------------------------------
// addsub_unit
//   Combinational WIDTH-bit add/subtract built on a parallel-prefix
//   (Kogge-Stone) carry-lookahead adder. Subtract is A + ~B + 1 in a single
//   pass: B is inverted and the carry-in is the op bit, so B = most-negative
//   needs no special handling.
//
//   Ports:
//     a, b     : signed operands
//     op       : OP_ADD / OP_SUB
//     result   : a +/- b, wraps mod 2^WIDTH
//     carry    : carry out of the adder (for SUB: 1 = no borrow)
//     overflow : signed overflow
//     zero     : result == 0
// ----------------------------------------------------------------------------
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  addsub_op_e       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] prop;     // per-bit propagate, kept for the sum
  logic [WIDTH-1:0] grp_g;    // group generate, refined per prefix level
  logic [WIDTH-1:0] grp_p;    // group propagate, refined per prefix level
  logic [WIDTH-1:0] nxt_g;
  logic [WIDTH-1:0] nxt_p;
  logic [WIDTH-1:0] carries;  // carry into each bit position

  assign cin   = (op == OP_SUB);
  assign b_eff = b ^ {WIDTH{cin}};
  assign prop  = a ^ b_eff;

  // NOTE: this process reuses grp_g/grp_p as scratch across loop levels, so
  // it must use blocking assignments; every variable is given a value at the
  // top so no latch can be inferred.
  always_comb begin
    grp_g = a & b_eff;
    grp_p = prop;
    nxt_g = '0;
    nxt_p = '0;
    // Fold the carry-in into bit 0 so G[i] becomes the carry out of bit i.
    grp_g[0] = grp_g[0] | (grp_p[0] & cin);
    for (int d = 1; d < WIDTH; d = d * 2) begin
      nxt_g = grp_g;
      nxt_p = grp_p;
      for (int i = d; i < WIDTH; i++) begin
        nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        nxt_p[i] = grp_p[i] & grp_p[i-d];
      end
      grp_g = nxt_g;
      grp_p = nxt_p;
    end
  end

  assign carries = {grp_g[WIDTH-2:0], cin};
  assign result  = prop ^ carries;
  assign carry   = grp_g[WIDTH-1];
  assign zero    = (result == '0);

  always_comb begin
    if (op == OP_SUB) begin
      overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end else begin
      overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/addsub_share_ctrl.sv
// ----------------------------------------------------------------------------
// addsub_share_ctrl
//   Round-robin controller time-sharing one add/subtract datapath among
//   NUM_REQ requesters. At most one request is granted per cycle, only when
//   the one-entry output slot is free (empty or draining this cycle). The
//   result, flags and requester id are registered into the slot and offered
//   on a valid/ready handshake.
//
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     req_valid[i]      : requester i has a pending operation
//     req_ready[i]      : one-hot grant (combinational)
//     req_a/req_b[i]    : signed operands of requester i
//     req_op[i]         : 0 = A+B, 1 = A-B
//     rsp_valid/ready   : output slot handshake
//     rsp_id            : index of the requester that produced the result
//     rsp_result        : sum/difference, wraps mod 2^WIDTH
//     rsp_overflow      : signed overflow
//     rsp_carry         : adder carry out (SUB: 1 = no borrow)
//     rsp_zero          : rsp_result == 0
// ----------------------------------------------------------------------------
module addsub_share_ctrl
  import addsub_pkg::*;
#(
  parameter int NUM_REQ = ADDSUB_NUM_REQ,
  parameter int WIDTH   = ADDSUB_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]              req_op,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [WIDTH-1:0]                rsp_result,
  output logic                            rsp_overflow,
  output logic                            rsp_carry,
  output logic                            rsp_zero
);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             carry;
    logic             zero;
  } slot_t;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  next_ptr;
  logic             grant_found;
  logic             slot_free;
  logic             accept;

  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  addsub_op_e       mux_op;
  logic [WIDTH-1:0] unit_result;
  logic             unit_carry;
  logic             unit_overflow;
  logic             unit_zero;

  slot_t            slot_q;
  logic             slot_valid_q;

  // --------------------------------------------------------------------------
  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[rr_wrap(32'(rr_ptr), k, NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(rr_wrap(32'(rr_ptr), k, NUM_REQ));
      end
    end
  end

  assign next_ptr  = ID_W'(rr_wrap(32'(grant_idx), 1, NUM_REQ));
  assign slot_free = !slot_valid_q || rsp_ready;

  // Grant is suppressed during reset so no accept can coincide with it.
  always_comb begin
    req_ready = '0;
    if (!rst && slot_free && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  // --------------------------------------------------------------------------
  // Operand mux and shared datapath
  // --------------------------------------------------------------------------
  assign mux_a  = req_a[grant_idx];
  assign mux_b  = req_b[grant_idx];
  assign mux_op = addsub_op_e'(req_op[grant_idx]);

  addsub_unit #(
    .WIDTH (WIDTH)
  ) u_addsub_unit (
    .a        (mux_a),
    .b        (mux_b),
    .op       (mux_op),
    .result   (unit_result),
    .carry    (unit_carry),
    .overflow (unit_overflow),
    .zero     (unit_zero)
  );

  // --------------------------------------------------------------------------
  // Output slot and round-robin pointer
  // --------------------------------------------------------------------------
  // NOTE: the slot data fields are reset as well as the valid bit, because
  // the outputs are observable and must read as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
      rr_ptr       <= '0;
    end else if (accept) begin
      // Covers the drain-and-refill case: no bubble between results.
      slot_valid_q    <= 1'b1;
      slot_q.id       <= grant_idx;
      slot_q.result   <= unit_result;
      slot_q.overflow <= unit_overflow;
      slot_q.carry    <= unit_carry;
      slot_q.zero     <= unit_zero;
      rr_ptr          <= next_ptr;
    end else if (rsp_ready) begin
      // Drain only: data fields keep their last value.
      slot_valid_q <= 1'b0;
    end
  end

  assign rsp_valid    = slot_valid_q;
  assign rsp_id       = slot_q.id;
  assign rsp_result   = slot_q.result;
  assign rsp_overflow = slot_q.overflow;
  assign rsp_carry    = slot_q.carry;
  assign rsp_zero     = slot_q.zero;

endmodule
